// File: rtl/fft_image_mem_sequencer.sv
// ---------------------------------------------------------------------------
// fft_image_mem_sequencer
//
// Phase controller for the FFT image-memory path. A context is started with
// a single-cycle start pulse carrying its tile count. During LOAD, each 2-D
// FFT result (fft_next_out_i) becomes one write into the four image-memory
// blocks. During DRAIN the same number of tiles is read back to the output
// FIFO as cachelines. FLUSH waits out the memory read latency. DONE pulses
// once when the last cacheline has been presented.
//
// Parameters
//   ADDR_W  memory address width; capacity DEPTH = 2**ADDR_W tiles
//   RD_LAT  memory read latency, read address -> data valid (1..4)
//
// Ports
//   clk_i                clock
//   reset_i              synchronous reset, active high
//   start_i              1-cycle pulse, begins a context (ignored unless idle)
//   ctx_length_i         tiles per context, sampled on an accepted start
//   fft_next_out_i       one pulse per finished tile result
//   output_fifo_full_i   FIFO almost-full; stalls read issue only
//   mem_we_o             write enable to all memory blocks
//   mem_write_address_o  write address to all memory blocks
//   mem_read_address_o   read address to all memory blocks
//   output_valid_o       cacheline_out valid this cycle
//   busy_o               high in every state except IDLE
//   done_o               1-cycle pulse, context fully drained
//   error_o              sticky: oversize context or stray fft_next_out_i
// ---------------------------------------------------------------------------
module fft_image_mem_sequencer #(
  parameter int ADDR_W = 13,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [31:0]       ctx_length_i,
  input  logic              fft_next_out_i,
  input  logic              output_fifo_full_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_write_address_o,
  output logic [ADDR_W-1:0] mem_read_address_o,
  output logic              output_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam logic [31:0]     DEPTH      = 32'(1) << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [2:0]      FLUSH_LAST = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // Counters are one bit wider than the address so a full-depth context
  // (len == DEPTH) is distinguishable from an empty one.
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] acc_cnt_q, acc_cnt_d;  // fft_next_out pulses accepted
  logic [ADDR_W:0] wr_cnt_q, wr_cnt_d;    // writes performed (mem_we seen)
  logic [ADDR_W:0] rd_cnt_q, rd_cnt_d;    // reads issued
  logic            we_q, we_d;
  logic            error_q, error_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic [RD_LAT-1:0] vld_q;               // issue strobe delay line

  logic issue;
  logic next_accept;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_cnt_d   = acc_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    we_d        = 1'b0;
    error_d     = error_q;
    flush_cnt_d = flush_cnt_q;
    issue       = 1'b0;
    next_accept = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (ctx_length_i > DEPTH) begin
            error_d = 1'b1;
          end else begin
            len_d     = ctx_length_i[ADDR_W:0];
            acc_cnt_d = '0;
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            state_d   = (ctx_length_i == '0) ? S_DONE : S_LOAD;
          end
        end
      end

      S_LOAD: begin
        // Pulses beyond len are refused even though the matching write
        // (one cycle later) may still be in flight.
        next_accept = fft_next_out_i && (acc_cnt_q < len_q);
        if (we_q) begin
          wr_cnt_d = wr_cnt_q + CNT_ONE;
          if (wr_cnt_q + CNT_ONE == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        issue = !output_fifo_full_i && (rd_cnt_q < len_q);
        if (issue) begin
          rd_cnt_d = rd_cnt_q + CNT_ONE;
          if (rd_cnt_q + CNT_ONE == len_q) begin
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
          end
        end
      end

      // The last issued read surfaces on output_valid in the final FLUSH
      // cycle, so DONE lands exactly one cycle after it.
      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = S_DONE;
        end else begin
          flush_cnt_d = flush_cnt_q + 3'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (next_accept) begin
      acc_cnt_d = acc_cnt_q + CNT_ONE;
      we_d      = 1'b1;
    end else if (fft_next_out_i) begin
      error_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      acc_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      we_q        <= 1'b0;
      error_q     <= 1'b0;
      flush_cnt_q <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_cnt_q   <= acc_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      we_q        <= we_d;
      error_q     <= error_d;
      flush_cnt_q <= flush_cnt_d;
      // Valid trails issue by exactly RD_LAT cycles regardless of FIFO state;
      // the almost-full threshold leaves room for every read in flight.
      vld_q       <= RD_LAT'({vld_q, issue});
    end
  end

  // The write address is the write count, so it advances the cycle after
  // each mem_we; the read address likewise follows the issued-read count.
  assign mem_we_o            = we_q;
  assign mem_write_address_o = wr_cnt_q[ADDR_W-1:0];
  assign mem_read_address_o  = rd_cnt_q[ADDR_W-1:0];
  assign output_valid_o      = vld_q[RD_LAT-1];
  assign busy_o              = (state_q != S_IDLE);
  assign done_o              = (state_q == S_DONE);
  assign error_o             = error_q;

endmodule

// File: tb/tb_fft_image_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_image_mem_sequencer
//
// Directed bench for fft_image_mem_sequencer (ADDR_W=13, RD_LAT=2).
// Expected write addresses are queued as each fft_next_out pulse is driven;
// expected read order is queued when a context starts. A negedge monitor
// pops and compares them against mem_we / output_valid as they appear.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_image_mem_sequencer;

  localparam int ADDR_W = 13;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [31:0]       ctx_length;
  logic              fft_next_out;
  logic              fifo_full;
  logic              mem_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic              error;

  fft_image_mem_sequencer #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .start_i             (start),
    .ctx_length_i        (ctx_length),
    .fft_next_out_i      (fft_next_out),
    .output_fifo_full_i  (fifo_full),
    .mem_we_o            (mem_we),
    .mem_write_address_o (wr_addr),
    .mem_read_address_o  (rd_addr),
    .output_valid_o      (out_valid),
    .busy_o              (busy),
    .done_o              (done),
    .error_o             (error)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int valid_cnt   = 0;
  int last_valid_cyc = 0;
  int wr_idx      = 0;

  typedef struct {
    int addr;
    int cyc;
  } iss_t;

  int   wq[$];      // expected write addresses, in order
  int   exp_rd[$];  // expected read addresses behind each output_valid
  iss_t iq[$];      // reads seen issued (address + issue cycle)

  logic [ADDR_W-1:0] prev_rd;
  iss_t              iss_e;
  int                exp_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor. A read issued in cycle T shows up as the read
  // address stepping by one at sample T+1.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      prev_rd = rd_addr;
    end else begin
      if (mem_we === 1'b1) begin
        check("we_expected", longint'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          exp_v = wq.pop_front();
          check("we_addr", wr_addr, exp_v);
        end
      end
      if (rd_addr == prev_rd + 1'b1) begin
        iq.push_back('{addr: int'(prev_rd), cyc: cyc - 1});
      end
      prev_rd = rd_addr;
      if (out_valid === 1'b1) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        check("valid_expected", longint'(iq.size() > 0 && exp_rd.size() > 0), 1);
        if (iq.size() > 0 && exp_rd.size() > 0) begin
          iss_e = iq.pop_front();
          exp_v = exp_rd.pop_front();
          check("valid_addr", iss_e.addr, exp_v);
          check("valid_latency", cyc - iss_e.cyc, RD_LAT);
        end
      end
    end
  end

  task automatic do_start(input int len);
    @(posedge clk); #1;
    start      = 1'b1;
    ctx_length = len;
    if (len > 0 && len <= DEPTH) begin
      for (int i = 0; i < len; i++) exp_rd.push_back(i);
    end
    wr_idx    = 0;
    valid_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulses(input int n, input int gap);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      fft_next_out = 1'b1;
      wq.push_back(wr_idx);
      wr_idx++;
      @(posedge clk); #1;
      fft_next_out = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_rd_addr(input int a, input int budget);
    bit hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      if (rd_addr == ADDR_W'(a)) hit = 1'b1;
    end
    check("reach_rd_addr", hit, 1);
  endtask

  task automatic wait_done(input int len, input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("valid_count", valid_cnt, len);
      if (len > 0) check("done_after_last_valid", cyc - last_valid_cyc, 1);
      check("rd_queue_empty", exp_rd.size(), 0);
      check("wr_queue_empty", wq.size(), 0);
      @(negedge clk);
      check("done_width", done, 0);
      check("busy_after_done", busy, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    mem_we,    0);
    check({tag, "_waddr"}, wr_addr,   0);
    check({tag, "_raddr"}, rd_addr,   0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_done"},  done,      0);
    check({tag, "_error"}, error,     0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    ctx_length   = '0;
    fft_next_out = 1'b0;
    fifo_full    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: len=4, next_out every other cycle, FIFO never full
    do_start(4);
    @(negedge clk);
    check("t1_busy", busy, 1);
    pulses(4, 1);
    wait_done(4, 60);

    // 2: len=8, FIFO full for 3 cycles mid-drain freezes the read address
    do_start(8);
    pulses(8, 0);
    wait_rd_addr(3, 60);
    @(posedge clk); #1;
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_frozen_addr", rd_addr, 4);
    end
    @(posedge clk); #1;
    fifo_full = 1'b0;
    wait_done(8, 60);

    // 3: len=0 goes straight to DONE for one cycle
    do_start(0);
    @(negedge clk);
    check("t3_done", done, 1);
    check("t3_busy", busy, 1);
    @(negedge clk);
    check("t3_done_clear", done, 0);
    check("t3_busy_clear", busy, 0);
    check("t3_valids", valid_cnt, 0);

    // 4: full-depth context; last write lands before any read
    do_start(DEPTH);
    pulses(DEPTH, 0);
    @(negedge clk);
    check("t4_last_we", mem_we, 1);
    check("t4_last_waddr", wr_addr, DEPTH - 1);
    check("t4_no_early_valid", valid_cnt, 0);
    check("t4_no_early_read", rd_addr, 0);
    wait_done(DEPTH, DEPTH + 60);

    // 5: oversize context flags error and stays idle; stray pulse ignored
    do_start(9000);
    @(negedge clk);
    check("t5_error", error, 1);
    check("t5_idle", busy, 0);
    @(posedge clk); #1;
    fft_next_out = 1'b1;
    @(posedge clk); #1;
    fft_next_out = 1'b0;
    @(negedge clk);
    check("t5_no_we", mem_we, 0);
    check("t5_error_sticky", error, 1);

    // 6: reset mid-drain, then a clean len=2 context
    do_start(6);
    pulses(6, 0);
    wait_rd_addr(3, 60);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("t6_reset");
    wq.delete();
    exp_rd.delete();
    iq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    do_start(2);
    pulses(2, 0);
    wait_done(2, 60);
    check("t6_error_clear", error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
